// File: rtl/alu_sequencer.sv
// alu_sequencer: request-side controller for the 32-bit datapath ALU.
// Accepts an operation over a valid/ready request channel and drives the ALU
// operand buses and control code from registers. It then captures the
// combinational ALU result and flags into a valid/ready response channel.
//
// Build option: define ALU_SEQ_MULTISHIFT_EN to build the SHIFT state.
// With it, SLL accepts shift amounts up to 31 and issues repeated ALU passes
// of at most SLL_STEP. Without it, SLL is a single pass using b[1:0].
module alu_sequencer #(
    parameter int DATA_W   = 32,
    parameter int SLL_STEP = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              alu_negative,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_carry,
    output logic              rsp_negative
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef ALU_SEQ_MULTISHIFT_EN
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam int         SH_W    = 5;
`else
    // Width of the shift field the ALU itself honours (busB[1:0]).
    localparam int         STEP_W  = $clog2(SLL_STEP + 1);
`endif
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_req_ready;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_ctrl;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_overflow;
    logic              r_rsp_carry;
    logic              r_rsp_negative;

    logic              w_accept;
    logic              w_exec_done;
    logic              w_is_addsub;
    logic [DATA_W-1:0] w_exec_b;

`ifdef ALU_SEQ_MULTISHIFT_EN
    logic [SH_W-1:0]   r_rem;
    logic [SH_W-1:0]   w_shamt;
    logic [SH_W-1:0]   w_step_new;
    logic [SH_W-1:0]   w_step_nxt;
    logic              w_go_shift;
    logic              w_shift_done;

    // One ALU pass shifts by min(remaining, SLL_STEP).
    function automatic logic [SH_W-1:0] f_step(input logic [SH_W-1:0] rem);
        return (rem > SH_W'(SLL_STEP)) ? SH_W'(SLL_STEP) : rem;
    endfunction

    assign w_shamt      = req_b[SH_W-1:0];
    assign w_step_new   = f_step(w_shamt);
    assign w_step_nxt   = f_step(r_rem);
    assign w_go_shift   = w_accept && (req_op == OP_SLL) && (w_shamt != '0);
    assign w_shift_done = (r_state == S_SHIFT) && (r_rem == '0);
`endif

    // req_ready is only ever high in IDLE, so this is also the IDLE accept.
    assign w_accept    = req_valid & r_req_ready;
    assign w_exec_done = (r_state == S_EXEC);
    // During EXEC the control register still holds the latched opcode.
    assign w_is_addsub = (r_alu_ctrl == OP_ADD) || (r_alu_ctrl == OP_SUB);

    // Operand B for a single EXEC pass; SLL is trimmed to what the ALU honours.
    always_comb begin
        w_exec_b = req_b;
        if (req_op == OP_SLL) begin
`ifdef ALU_SEQ_MULTISHIFT_EN
            // Only a zero shift reaches EXEC in this build.
            w_exec_b = '0;
`else
            w_exec_b = {{(DATA_W-STEP_W){1'b0}}, req_b[STEP_W-1:0]};
`endif
        end
    end

    // Control FSM: state, request-side ready and remaining shift amount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
            r_rem       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_state     <= S_EXEC;
`ifdef ALU_SEQ_MULTISHIFT_EN
                        if (w_go_shift) begin
                            r_state <= S_SHIFT;
                            r_rem   <= w_shamt - w_step_new;
                        end
`endif
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_EXEC: r_state <= S_RESP;
`ifdef ALU_SEQ_MULTISHIFT_EN
                S_SHIFT: begin
                    if (r_rem == '0) r_state <= S_RESP;
                    else             r_rem   <= r_rem - w_step_nxt;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU drive registers: loaded on accept, re-fed each shift pass, else NOP/0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= OP_NOP;
        end else begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= OP_NOP;
            if (r_state == S_IDLE && w_accept) begin
                r_alu_a    <= req_a;
                r_alu_ctrl <= req_op;
                r_alu_b    <= w_exec_b;
`ifdef ALU_SEQ_MULTISHIFT_EN
                if (w_go_shift)
                    r_alu_b <= {{(DATA_W-SH_W){1'b0}}, w_step_new};
`endif
            end
`ifdef ALU_SEQ_MULTISHIFT_EN
            else if (r_state == S_SHIFT && r_rem != '0) begin
                // Working value is the previous pass result.
                r_alu_a    <= alu_out;
                r_alu_b    <= {{(DATA_W-SH_W){1'b0}}, w_step_nxt};
                r_alu_ctrl <= OP_SLL;
            end
`endif
        end
    end

    // Response capture at the edge ending the final pass; held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_negative <= 1'b0;
        end else begin
            if (w_exec_done) begin
                r_rsp_valid <= 1'b1;
                if (r_alu_ctrl == OP_NOP) begin
                    r_rsp_data     <= '0;
                    r_rsp_zero     <= 1'b1;
                    r_rsp_negative <= 1'b0;
                    r_rsp_overflow <= 1'b0;
                    r_rsp_carry    <= 1'b0;
                end else begin
                    r_rsp_data     <= alu_out;
                    r_rsp_zero     <= alu_zero;
                    r_rsp_negative <= alu_negative;
                    r_rsp_overflow <= w_is_addsub & alu_overflow;
                    r_rsp_carry    <= w_is_addsub & alu_carry;
                end
            end
`ifdef ALU_SEQ_MULTISHIFT_EN
            else if (w_shift_done) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= alu_out;
                r_rsp_zero     <= alu_zero;
                r_rsp_negative <= alu_negative;
                r_rsp_overflow <= 1'b0;
                r_rsp_carry    <= 1'b0;
            end
`endif
            else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ctrl     = r_alu_ctrl;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_negative = r_rsp_negative;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU.
// Honours ALU_SEQ_MULTISHIFT_EN the same way the design does.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero, alu_overflow, alu_carry, alu_negative;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_overflow, rsp_carry, rsp_negative;

    alu_sequencer #(.DATA_W(32), .SLL_STEP(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_carry(rsp_carry), .rsp_negative(rsp_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; carry/overflow are junk (1) for non add/sub ops and
    // NOP yields nonzero junk so the sequencer's masking is exercised.
    logic [32:0] sum;
    always_comb begin
        sum          = '0;
        alu_out      = '0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        case (alu_ctrl)
            3'd0: alu_out = alu_a | 32'd1;
            3'd1: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            3'd2: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out      = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            3'd3: alu_out = alu_a & alu_b;
            3'd4: alu_out = alu_a | alu_b;
            3'd5: alu_out = alu_a ^ alu_b;
            3'd6: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_out = alu_a << alu_b[1:0];
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_negative = alu_out[31];
    end

    typedef struct packed {
        logic [31:0] d;
        logic        z, v, c, n;
        logic [4:0]  lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] bseq[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected response straight from the request, independent of the ALU.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] u;
        longint      sa, sb2, r;
        e   = '0;
        e.lat = 5'd1;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (op)
            3'd0: e.d = 32'd0;
            3'd1: begin
                u = {32'd0, a} + {32'd0, b};
                e.d = u[31:0]; e.c = u[32];
                r = sa + sb2;
                e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: begin
                e.d = a - b; e.c = (a >= b);
                r = sa - sb2;
                e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd3: e.d = a & b;
            3'd4: e.d = a | b;
            3'd5: e.d = a ^ b;
            3'd6: e.d = (sa < sb2) ? 32'd1 : 32'd0;
            default: begin
`ifdef ALU_SEQ_MULTISHIFT_EN
                e.d   = a << b[4:0];
                e.lat = (b[4:0] == 5'd0) ? 5'd1 : 5'((b[4:0] + 5'd2) / 5'd3);
`else
                e.d   = a << b[1:0];
`endif
            end
        endcase
        e.z = (e.d == 32'd0);
        e.n = e.d[31];
        return e;
    endfunction

    // Drive one request, score its response, optionally stall the response.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int acc_wait);
        exp_t        e;
        int          lat;
        logic [31:0] sd;
        logic [3:0]  sf;
        bseq.delete();
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        acc_wait = 0;
        while (!req_ready && acc_wait < 64) begin
            @(posedge clk); #1; acc_wait++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb.push_back(ref_model(op, a, b));
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (alu_ctrl == 3'b111) bseq.push_back(alu_b);
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        if (!rsp_valid) return;
        chk("data", rsp_data, e.d);
        chk("zero", 32'(rsp_zero), 32'(e.z));
        chk("ovf", 32'(rsp_overflow), 32'(e.v));
        chk("carry", 32'(rsp_carry), 32'(e.c));
        chk("neg", 32'(rsp_negative), 32'(e.n));
        if (hold > 0) begin
            sd = rsp_data;
            sf = {rsp_zero, rsp_overflow, rsp_carry, rsp_negative};
            req_op = 3'd1; req_a = 32'hDEAD; req_b = 32'hBEEF; req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_data", rsp_data, sd);
                chk("bp_flags", 32'({rsp_zero, rsp_overflow, rsp_carry, rsp_negative}), 32'(sf));
                chk("bp_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hs_valid", 32'(rsp_valid), 32'd0);
        chk("hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    int w;
    int seen;

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_flags", 32'({rsp_zero, rsp_overflow, rsp_carry, rsp_negative}), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_alu_ab", alu_a | alu_b, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        send(3'd1, 32'h7FFFFFFF, 32'd1, 0, w);
        send(3'd2, 32'd5, 32'd5, 0, w);
        send(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 0, w);
        send(3'd7, 32'd1, 32'd31, 0, w);
`ifdef ALU_SEQ_MULTISHIFT_EN
        chk("sll31_passes", 32'(bseq.size()), 32'd11);
        if (bseq.size() == 11) begin
            seen = 0;
            for (int i = 0; i < 10; i++) if (bseq[i] == 32'd3) seen++;
            chk("sll31_steps3", 32'(seen), 32'd10);
            chk("sll31_last", bseq[10], 32'd1);
        end
`endif
        send(3'd7, 32'h1234, 32'd0, 0, w);
        send(3'd7, 32'h1, 32'd3, 0, w);
        send(3'd7, 32'h1, 32'd4, 0, w);
`ifdef ALU_SEQ_MULTISHIFT_EN
        chk("sll4_passes", 32'(bseq.size()), 32'd2);
        if (bseq.size() == 2) chk("sll4_seq", {bseq[0][15:0], bseq[1][15:0]}, 32'h00030001);
`endif
        send(3'd0, 32'h5, 32'h9, 0, w);
        send(3'd6, 32'hFFFFFFFF, 32'd1, 0, w);
        send(3'd5, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, w);
        send(3'd2, 32'h80000000, 32'd1, 0, w);

        // Backpressure, then the next request must be taken right away.
        send(3'd1, 32'hFFFFFFFF, 32'd1, 5, w);
        send(3'd4, 32'h10, 32'h01, 0, w);
        chk("bp_next_accept_wait", 32'(w), 32'd0);

        // Abort an SLL in flight with an asynchronous reset.
        req_op = 3'd7; req_a = 32'd1; req_b = 32'd31; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_shift_ctrl", 32'(alu_ctrl), 32'd7);
`endif
        rst_n = 1'b0; #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        send(3'd4, 32'h1, 32'h2, 0, w);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (op == 3'd7) ? 32'($urandom_range(0, 31)) : $urandom;
            send(op, a, b, i % 3, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%h exp=%h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request-side controller for the 32-bit datapath ALU. It accepts operations over a valid/ready request channel and registers the operands. It drives the ALU's operand buses and 3-bit control code, then captures the ALU result and flags into a valid/ready response channel. Because the ALU's native SLL shifts by at most 3, SLL requests with shift amounts up to 31 are sequenced as repeated ALU passes.

## Interface
- `DATA_W`, 32, operand/result width; fixed to the ALU width.
- `SLL_STEP`, 3, maximum shift per ALU pass; the ALU uses `busB[1:0]`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  3  000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SLT, 111 SLL.
- `req_a`, `req_b`  in  32  operands; for SLL, `req_b[4:0]` is the shift amount.
- `alu_a`, `alu_b`  out  32  to ALU `busA`/`busB`.
- `alu_ctrl`  out  3  to ALU `Ctrl`.
- `alu_out`  in  32  ALU result.
- `alu_zero`, `alu_overflow`, `alu_carry`, `alu_negative`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  32  captured result.
- `rsp_zero`, `rsp_overflow`, `rsp_carry`, `rsp_negative`  out  1 each  captured flags.

## Operation
- FSM states: IDLE, EXEC, SHIFT, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid&req_ready`, latch op, a and b.
  - SLL with `b[4:0]`≠0 goes to SHIFT. All other ops, including SLL with shift 0, go to EXEC.
- **EXEC**
  - Drive `alu_a`=a, `alu_b`=b and `alu_ctrl`=op. For SLL with shift 0, drive `alu_b`=0.
  - Capture `alu_out` and flags, then go to RESP.
- **SHIFT**
  - Drive `alu_ctrl`=SLL and `alu_a`=working value. The working value is initialised to a.
  - Drive `alu_b`=min(remaining, 3). Remaining is initialised to `b[4:0]`.
  - Each cycle: working value ← `alu_out`, remaining ← remaining − step.
  - When remaining reaches 0, capture the final `alu_out`, zero and negative, then go to RESP.
  - Pass count = ceil(shamt/3); shamt 31 takes 11 passes.
- **RESP**
  - `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`.
  - On `rsp_valid&rsp_ready`, go to IDLE.
- Flag rules:
  - `rsp_carry`/`rsp_overflow` pass through from the ALU for ADD/SUB only; they are forced 0 for all other ops.
  - NOP returns data 0 with zero=1.
- In IDLE and RESP: `alu_ctrl`=000 (NOP) and `alu_a`=`alu_b`=0.
- `req_ready`=0 in EXEC, SHIFT and RESP. `req_valid` in those states is ignored.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE.
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, all `rsp_*` flags=0.
  - `alu_a`=`alu_b`=0, `alu_ctrl`=000.
- `req_ready` is registered: it rises at the first clock edge after `rst_n` deasserts.
- Latency:
  - Request accepted at edge N.
  - Single-pass op: `rsp_valid` rises at edge N+1.
  - SLL with P passes: `rsp_valid` rises at edge N+P.
- Response handshake at edge M: `rsp_valid` falls and `req_ready` rises at edge M. The earliest next acceptance is edge M+1.
- The ALU is combinational: `alu_*` outputs are registered, and `alu_out`/flags are sampled at the same edge that ends the pass.
- Reset asserted mid-EXEC, mid-SHIFT or mid-RESP: the operation is aborted immediately, all outputs take reset values, and no response is produced.
- Shift boundaries:
  - shamt 3: 1 pass.
  - shamt 4: 2 passes (3, then 1).
  - shamt 31: 10×3 then 1.

## Configuration
- `ALU_SEQ_MULTISHIFT_EN` defined:
  - SLL uses `req_b[4:0]` with multi-pass sequencing through SHIFT, as above.
- `ALU_SEQ_MULTISHIFT_EN` undefined:
  - The SHIFT state is not built.
  - SLL is a single EXEC pass with `alu_b`={30'b0, b[1:0]}; `b[31:2]` is ignored.
  - Latency is 1 for every op.

## Test plan
- ADD a=0x7FFFFFFF, b=1, accepted at edge N:
  - `rsp_valid` at N+1.
  - data=0x80000000, overflow=1, negative=1, zero=0.
- SUB a=5, b=5:
  - data=0, zero=1, negative=0, overflow=0.
  - AND a=0xF0F0F0F0, b=0xFF00FF00 gives data=0xF000F000, with carry=overflow=0.
- SLL a=1, b=31 with macro defined:
  - `alu_b` sequence is 3 (×10) then 1.
  - data=0x80000000, negative=1.
  - `rsp_valid` at N+11.
  - The same stimulus without the macro gives data=0x00000008 at N+1.
- SLL a=0x1234, b=0: single pass, data=0x1234, `rsp_valid` at N+1.
- Backpressure:
  - With `rsp_ready` held 0 for 5 cycles, `rsp_*` stays stable, `req_ready`=0, and a concurrent `req_valid` is ignored.
  - Raise `rsp_ready`: IDLE follows and the next request is accepted one edge later.
- Reset mid-operation:
  - Pulse `rst_n` low during the 4th SLL pass.
  - `rsp_valid` and `alu_ctrl` go to 0 immediately, and no response appears.
  - A following OR a=0x1, b=0x2 returns data 0x3.
